// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the iterative divide unit: op encodings,
// controller state enum and the default datapath width.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIN  = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// Issue-side handshake and write-back bundle of div_unit; master is the
// issue/regfile side, slave is the divider.
interface div_unit_if #(
  parameter int unsigned XLEN = riscv_pkg::XLEN_DEFAULT
) ();
  logic            start;
  logic            kill;
  logic [1:0]      op;
  logic [4:0]      rd_in;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            busy;
  logic            done;
  logic [4:0]      rd_out;
  logic            we;
  logic [XLEN-1:0] write_data;

  modport master (
    output start, kill, op, rd_in, rs1_data, rs2_data,
    input  busy, done, rd_out, we, write_data
  );

  modport slave (
    input  start, kill, op, rd_in, rs1_data, rs2_data,
    output busy, done, rd_out, we, write_data
  );
endinterface

// File: rtl/div_unit_step.sv
// One radix-2 restoring step: shift in the next dividend bit and subtract
// the divisor when the partial remainder stays non-negative.
module div_step #(
  parameter int unsigned XLEN = riscv_pkg::XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            dvd_bit_i,
  output logic [XLEN-1:0] rem_o,
  output logic            quo_bit_o
);
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    shifted   = {rem_i, dvd_bit_i};
    diff      = shifted - {1'b0, divisor_i};
    quo_bit_o = ~diff[XLEN];
    rem_o     = quo_bit_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  end
endmodule

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit, one quotient bit per cycle.
// Define DIV_EARLY_OUT_EN to short-circuit divide-by-zero and signed overflow.
module div_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);
  localparam int unsigned CW = $clog2(XLEN);

  div_state_e      state_q;
  div_op_e         op_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] dvd_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic            neg_q;
  logic [CW-1:0]   cnt_q;
  logic            done_q;
  logic            we_q;
  logic [XLEN-1:0] wdata_q;

  logic [XLEN-1:0] rem_d;
  logic            qbit_d;

  div_op_e         op_in;
  logic            sgn_in;
  logic            neg_in;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;
  logic [XLEN-1:0] res_quo;
  logic [XLEN-1:0] res_rem;
  logic            is_rem_q;

  always_comb begin
    op_in  = div_op_e'(bus.op);
    sgn_in = (op_in == DIV_OP_DIV) || (op_in == DIV_OP_REM);
    abs1   = (sgn_in && bus.rs1_data[XLEN-1]) ? -bus.rs1_data : bus.rs1_data;
    abs2   = (sgn_in && bus.rs2_data[XLEN-1]) ? -bus.rs2_data : bus.rs2_data;
    if (op_in == DIV_OP_REM || op_in == DIV_OP_REMU)
      neg_in = sgn_in && bus.rs1_data[XLEN-1];
    else
      neg_in = sgn_in && (bus.rs1_data[XLEN-1] ^ bus.rs2_data[XLEN-1]);
  end

`ifdef DIV_EARLY_OUT_EN
  logic div0_in;
  logic ovf_in;
  always_comb begin
    div0_in = (bus.rs2_data == '0);
    ovf_in  = sgn_in && (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
              (bus.rs2_data == '1);
  end
`endif

  // A zero divisor leaves the dividend in rem_q, so only the quotient needs
  // forcing; signed overflow already falls out of the magnitude datapath.
  always_comb begin
    is_rem_q = (op_q == DIV_OP_REM) || (op_q == DIV_OP_REMU);
    res_rem  = neg_q ? -rem_q : rem_q;
    if (dvs_q == '0)
      res_quo = '1;
    else
      res_quo = neg_q ? -quo_q : quo_q;
  end

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .divisor_i (dvs_q),
    .dvd_bit_i (dvd_q[XLEN-1]),
    .rem_o     (rem_d),
    .quo_bit_o (qbit_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= DIV_OP_DIV;
      rd_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start && !bus.kill) begin
            op_q    <= op_in;
            rd_q    <= bus.rd_in;
            dvd_q   <= abs1;
            dvs_q   <= abs2;
            neg_q   <= neg_in;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= CALC;
`ifdef DIV_EARLY_OUT_EN
            if (div0_in || ovf_in) begin
              rem_q   <= div0_in ? abs1 : '0;
              quo_q   <= abs1;
              state_q <= FIN;
            end
`endif
          end
        end
        CALC: begin
          if (bus.kill) begin
            state_q <= IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= {quo_q[XLEN-2:0], qbit_d};
            dvd_q <= {dvd_q[XLEN-2:0], 1'b0};
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(XLEN-1))
              state_q <= FIN;
          end
        end
        FIN: begin
          if (bus.kill) begin
            state_q <= IDLE;
          end else begin
            wdata_q <= is_rem_q ? res_rem : res_quo;
            done_q  <= 1'b1;
            we_q    <= (rd_q != '0);
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.we         = we_q;
  assign bus.rd_out     = rd_q;
  assign bus.write_data = wdata_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M cases plus random operands
// checked against an arithmetic reference model.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  div_unit_if #(.XLEN(32)) bus ();
  div_unit #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00:   return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    if (b == 0 || (op[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
      return 1;
`endif
    return 33;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a request for one cycle, then scrambles operand lines.
  task automatic drive_start(input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd);
    bus.start    = 1'b1;
    bus.op       = op;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.rd_in    = rd;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.rs1_data = $urandom;
    bus.rs2_data = $urandom;
    bus.op       = 2'($urandom);
    bus.rd_in    = 5'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    int lat;
    drive_start(op, a, b, rd);
    wait_done(lat);
    chk({tag, ".lat"}, lat, exp_lat(op, a, b));
    chk({tag, ".data"}, bus.write_data, model(op, a, b));
    chk({tag, ".rd"}, bus.rd_out, rd);
    chk({tag, ".we"}, bus.we, (rd != 0));
    chk({tag, ".busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    int lat;
    int seen;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [31:0] held;

    rst = 1'b1;
    bus.start = 1'b0; bus.kill = 1'b0; bus.op = '0; bus.rd_in = '0;
    bus.rs1_data = '0; bus.rs2_data = '0;
    repeat (3) @(negedge clk);
    chk("rst.busy", bus.busy, 0);
    chk("rst.done", bus.done, 0);
    chk("rst.we", bus.we, 0);
    chk("rst.rd", bus.rd_out, 0);
    chk("rst.wdata", bus.write_data, 0);
    rst = 1'b0;
    @(negedge clk);

    do_op("divu", 2'b01, 32'd100, 32'd7, 5'd5);
    held = bus.write_data;
    @(negedge clk);
    chk("done_pulse", bus.done, 0);
    chk("we_pulse", bus.we, 0);
    chk("wdata_hold", bus.write_data, held);
    do_op("remu", 2'b11, 32'd100, 32'd7, 5'd5);
    do_op("div_neg", 2'b00, 32'hFFFF_FF9C, 32'd7, 5'd6);
    do_op("rem_neg", 2'b10, 32'hFFFF_FF9C, 32'd7, 5'd7);
    do_op("rem_negdiv", 2'b10, 32'd100, 32'hFFFF_FFF9, 5'd8);
    do_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    do_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    do_op("divu_z", 2'b01, 32'd5, 32'd0, 5'd11);
    do_op("remu_z", 2'b11, 32'd5, 32'd0, 5'd12);
    do_op("div_z", 2'b00, 32'hFFFF_FFFB, 32'd0, 5'd13);
    do_op("rem_z", 2'b10, 32'hFFFF_FFFB, 32'd0, 5'd14);
    do_op("rd0", 2'b01, 32'd10, 32'd2, 5'd0);
    chk("rd0.done", bus.done, 1);

    // start while busy must not disturb the operation in flight
    drive_start(2'b01, 32'd100, 32'd7, 5'd3);
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.rs1_data = 32'd1234; bus.rs2_data = 32'd3; bus.rd_in = 5'd20;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat);
    chk("ign.lat", lat + 10, 33);
    chk("ign.data", bus.write_data, 32'd14);
    chk("ign.rd", bus.rd_out, 5'd3);

    // back-to-back issue in the done cycle
    do_op("b2b", 2'b00, 32'd1000, 32'hFFFF_FFFD, 5'd4);

    drive_start(2'b01, 32'd77, 32'd5, 5'd2);
    repeat (14) @(negedge clk);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    chk("kill.busy", bus.busy, 0);
    seen = 0;
    repeat (40) begin
      if (bus.done === 1'b1 || bus.we === 1'b1) seen++;
      @(negedge clk);
    end
    chk("kill.nodone", seen, 0);

    drive_start(2'b01, 32'd99, 32'd4, 5'd2);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst.busy", bus.busy, 0);
    chk("mrst.done", bus.done, 0);
    chk("mrst.we", bus.we, 0);
    chk("mrst.rd", bus.rd_out, 0);
    chk("mrst.wdata", bus.write_data, 0);
    @(negedge clk);
    do_op("post_rst", 2'b00, 32'd12345, 32'd67, 5'd31);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2:       rb = 32'($urandom_range(1, 20));
        3:       rb = -32'($urandom_range(1, 20));
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      do_op($sformatf("rnd%0d", i), rop, ra, rb, 5'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
